sync_manager: RTL and testbench

SYNC_MANAGER -- requirements
Module: sync_manager

---
 rtl/sync_manager.sv | 185 ++++++++++++++++++
 tb/tb_sync_manager.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_manager.sv
// Measures active width/height from registered DE/VSYNC and emits delayed row/frame pulses.
// Optional SYNC_MANAGER_STABILITY_CHECK_EN: valid flags need two equal consecutive measurements.
module sync_manager #(
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080,
  parameter int DELAY      = 10
) (
  input  logic                          I_rgb_clk,
  input  logic                          I_rst,
  input  logic                          I_rgb_de,
  input  logic                          I_rgb_hsync,
  input  logic                          I_rgb_vsync,
  output logic [$clog2(MAX_WIDTH)-1:0]  O_image_width,
  output logic [$clog2(MAX_HEIGHT)-1:0] O_image_height,
  output logic                          O_width_valid,
  output logic                          O_height_valid,
  output logic                          O_new_row,
  output logic                          O_new_frame
);

  localparam int WW = $clog2(MAX_WIDTH);
  localparam int HW = $clog2(MAX_HEIGHT);
  localparam logic [WW:0] W_LIM = (WW+1)'(MAX_WIDTH);
  localparam logic [HW:0] H_LIM = (HW+1)'(MAX_HEIGHT);

  typedef enum logic {
    L_IDLE,
    L_ACTIVE
  } line_e;

  typedef enum logic {
    F_WAIT,
    F_RUN
  } frame_e;

  logic de_r;
  logic de_p;
  logic vs_r;
  logic vs_p;
  logic prime1;
  logic prime2;
  logic de_rise;
  logic de_fall;
  logic vs_rise;

  line_e  line_q;
  line_e  line_d;
  frame_e frame_q;
  frame_e frame_d;
  logic   load_w;
  logic   load_h;

  logic [WW-1:0] wcnt;
  logic [HW-1:0] hcnt;
  logic          w_in;
  logic          h_in;
  logic          w_ok;
  logic          h_ok;

  logic [DELAY-1:0] row_sr;
  logic [DELAY-1:0] frm_sr;

  logic hsync_unused;

  assign hsync_unused = I_rgb_hsync;

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      de_r   <= 1'b0;
      de_p   <= 1'b0;
      vs_r   <= 1'b0;
      vs_p   <= 1'b0;
      prime1 <= 1'b0;
      prime2 <= 1'b0;
    end else begin
      de_r   <= I_rgb_de;
      de_p   <= de_r;
      vs_r   <= I_rgb_vsync;
      vs_p   <= vs_r;
      prime1 <= 1'b1;
      prime2 <= prime1;
    end
  end

  // No edge is reported until two post-reset samples exist to compare.
  assign de_rise = prime2 & de_r & ~de_p;
  assign de_fall = prime2 & ~de_r & de_p;
  assign vs_rise = prime2 & vs_r & ~vs_p;

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      line_q  <= L_IDLE;
      frame_q <= F_WAIT;
    end else begin
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    line_d = line_q;
    load_w = 1'b0;
    if (de_rise) begin
      line_d = L_ACTIVE;
    end else if (de_fall) begin
      line_d = L_IDLE;
      load_w = (line_q == L_ACTIVE);
    end
  end

  always_comb begin
    frame_d = frame_q;
    load_h  = 1'b0;
    if (vs_rise) begin
      frame_d = F_RUN;
      load_h  = (frame_q == F_RUN);
    end
  end

  assign w_in = (wcnt != '0) && ({1'b0, wcnt} <= W_LIM);
  assign h_in = (hcnt != '0) && ({1'b0, hcnt} <= H_LIM);

`ifdef SYNC_MANAGER_STABILITY_CHECK_EN
  assign w_ok = w_in && (wcnt == O_image_width);
  assign h_ok = h_in && (hcnt == O_image_height);
`else
  assign w_ok = w_in;
  assign h_ok = h_in;
`endif

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      wcnt          <= '0;
      O_image_width <= '0;
      O_width_valid <= 1'b0;
    end else begin
      if (de_rise) begin
        wcnt <= WW'(1);
      end else if (de_r && line_q == L_ACTIVE && wcnt != '1) begin
        wcnt <= wcnt + WW'(1);
      end
      if (load_w) begin
        O_image_width <= wcnt;
        O_width_valid <= w_ok;
      end
    end
  end

  // A DE rise coincident with VSYNC rise belongs to the new frame.
  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      hcnt           <= '0;
      O_image_height <= '0;
      O_height_valid <= 1'b0;
    end else begin
      if (vs_rise) begin
        hcnt <= de_rise ? HW'(1) : '0;
      end else if (de_rise && hcnt != '1) begin
        hcnt <= hcnt + HW'(1);
      end
      if (load_h) begin
        O_image_height <= hcnt;
        O_height_valid <= h_ok;
      end
    end
  end

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      row_sr <= '0;
      frm_sr <= '0;
    end else begin
      row_sr[0] <= de_fall;
      frm_sr[0] <= vs_rise;
      for (int i = 1; i < DELAY; i++) begin
        row_sr[i] <= row_sr[i-1];
        frm_sr[i] <= frm_sr[i-1];
      end
    end
  end

  assign O_new_row   = row_sr[DELAY-1];
  assign O_new_frame = frm_sr[DELAY-1];

endmodule

// File: tb/tb_sync_manager.sv
// Scoreboard bench for sync_manager: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares pulses and measurements.
module tb_sync_manager;

  localparam int DLY = 10;
`ifdef SYNC_MANAGER_STABILITY_CHECK_EN
  localparam bit NV = 1'b0;
`else
  localparam bit NV = 1'b1;
`endif

  typedef struct {
    int val;
    bit v;
  } exp_t;

  typedef struct {
    int t;
    bit h;
    int val;
    bit v;
  } meas_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rgb_de = 1'b0;
  logic        rgb_hs = 1'b0;
  logic        rgb_vs = 1'b0;
  logic [10:0] image_width;
  logic [10:0] image_height;
  logic        width_valid;
  logic        height_valid;
  logic        new_row;
  logic        new_frame;

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    qr[$];
  int    qf[$];
  meas_t mq[$];
  exp_t  wt[$];
  exp_t  ht[$];

  bit m_prev_ok = 1'b0;
  bit m_de = 1'b0;
  bit m_vs = 1'b0;
  bit m_line_ok = 1'b0;
  bit m_frame_ok = 1'b0;

  sync_manager #(
    .MAX_WIDTH (1920),
    .MAX_HEIGHT(1080),
    .DELAY     (DLY)
  ) dut (
    .I_rgb_clk     (clk),
    .I_rst         (rst),
    .I_rgb_de      (rgb_de),
    .I_rgb_hsync   (rgb_hs),
    .I_rgb_vsync   (rgb_vs),
    .O_image_width (image_width),
    .O_image_height(image_height),
    .O_width_valid (width_valid),
    .O_height_valid(height_valid),
    .O_new_row     (new_row),
    .O_new_frame   (new_frame)
  );

  always #5 clk = ~clk;

  task automatic want_w(input int val, input bit v);
    wt.push_back('{val, v});
  endtask

  task automatic want_w4(input int val, input bit v0);
    want_w(val, v0);
    repeat (3) want_w(val, 1'b1);
  endtask

  task automatic want_h(input int val, input bit v);
    ht.push_back('{val, v});
  endtask

  task automatic tick(input logic de, input logic vs);
    exp_t e;
    bit   rise;
    bit   fall;
    bit   vr;
    rgb_de = de;
    rgb_vs = vs;
    @(posedge clk);
    cyc++;
    if (m_prev_ok) begin
      rise = de & ~m_de;
      fall = ~de & m_de;
      vr   = vs & ~m_vs;
      if (fall) begin
        qr.push_back(cyc + DLY);
        if (!m_line_ok) begin
          mq.push_back('{cyc + 1, 1'b0, 0, 1'b0});
        end else if (wt.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL width_table empty at cyc=%0d", cyc);
        end else begin
          e = wt.pop_front();
          mq.push_back('{cyc + 1, 1'b0, e.val, e.v});
        end
      end
      if (vr) begin
        qf.push_back(cyc + DLY);
        if (!m_frame_ok) begin
          mq.push_back('{cyc + 1, 1'b1, 0, 1'b0});
        end else if (ht.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL height_table empty at cyc=%0d", cyc);
        end else begin
          e = ht.pop_front();
          mq.push_back('{cyc + 1, 1'b1, e.val, e.v});
        end
        m_frame_ok = 1'b1;
      end
      if (rise) m_line_ok = 1'b1;
      if (fall) m_line_ok = 1'b0;
    end
    m_prev_ok = 1'b1;
    m_de = de;
    m_vs = vs;
    #1;
  endtask

  task automatic chk0(input string name, input int got);
    checks++;
    if (got != 0) begin
      failures++;
      $display("FAIL reset_%s got=%0d want=0 cyc=%0d", name, got, cyc);
    end
  endtask

  task automatic do_reset(input logic de, input int n);
    rst = 1'b1;
    qr.delete();
    qf.delete();
    m_prev_ok  = 1'b0;
    m_line_ok  = 1'b0;
    m_frame_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk0("width", int'(image_width));
      chk0("height", int'(image_height));
      chk0("wvalid", int'(width_valid));
      chk0("hvalid", int'(height_valid));
      chk0("new_row", int'(new_row));
      chk0("new_frame", int'(new_frame));
      rgb_de = de;
      rgb_vs = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic frame(input int w, input int nl);
    for (int l = 0; l < 16; l++) begin
      for (int t = 0; t < 16; t++) begin
        rgb_hs = (t >= 12);
        tick((l >= 1 && l <= nl && t >= 4 && t < 4 + w), (l == 0 && t < 2));
      end
    end
  endtask

  task automatic line(input int act, input int blank);
    repeat (act) tick(1'b1, 1'b0);
    repeat (blank) tick(1'b0, 1'b0);
  endtask

  task automatic chk_empty(input string name, input int sz);
    checks++;
    if (sz != 0) begin
      failures++;
      $display("FAIL %s_leftover got=%0d want=0", name, sz);
    end
  endtask

  always @(negedge clk) begin
    bit    er;
    bit    ef;
    meas_t m;
    int    gw;
    bit    gv;
    er = (qr.size() > 0) && (qr[0] == cyc);
    if (er) void'(qr.pop_front());
    if (er || new_row) begin
      checks++;
      if (new_row !== er) begin
        failures++;
        $display("FAIL new_row cyc=%0d got=%0b want=%0b", cyc, new_row, er);
      end
    end
    ef = (qf.size() > 0) && (qf[0] == cyc);
    if (ef) void'(qf.pop_front());
    if (ef || new_frame) begin
      checks++;
      if (new_frame !== ef) begin
        failures++;
        $display("FAIL new_frame cyc=%0d got=%0b want=%0b", cyc, new_frame, ef);
      end
    end
    while (mq.size() > 0 && mq[0].t <= cyc) begin
      m  = mq.pop_front();
      gw = m.h ? int'(image_height) : int'(image_width);
      gv = m.h ? height_valid : width_valid;
      checks++;
      if (m.t != cyc || gw != m.val || gv !== m.v) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0d/%0b want=%0d/%0b at cyc %0d",
                 m.h ? "height" : "width", cyc, gw, gv, m.val, m.v, m.t);
      end
    end
  end

  initial begin
    want_w4(4, NV);
    want_w4(4, 1'b1);
    want_w4(4, 1'b1);
    want_w4(6, NV);
    want_w4(4, NV);
    want_w(3, NV);
    want_w(1920, NV);
    want_w(1921, 1'b0);
    want_w(1, NV);
    want_w(1, 1'b1);
    want_w4(4, NV);
    want_h(4, NV);
    want_h(4, 1'b1);
    want_h(4, 1'b1);
    want_h(4, 1'b1);
    want_h(0, 1'b0);
    want_h(5, NV);
    want_h(4, NV);

    do_reset(1'b0, 3);
    repeat (4) tick(1'b0, 1'b0);
    repeat (3) frame(4, 4);
    frame(6, 4);
    frame(4, 0);
    frame(4, 4);
    repeat (3) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    line(1920, 8);
    line(1921, 8);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    do_reset(1'b1, 3);
    repeat (3) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    frame(4, 4);
    repeat (2) tick(1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0);

    chk_empty("row_q", qr.size());
    chk_empty("frame_q", qf.size());
    chk_empty("meas_q", mq.size());
    chk_empty("width_table", wt.size());
    chk_empty("height_table", ht.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
